mem_access_ctrl: RTL and testbench

//  Sequences every memory transfer through the shared MAR/MDR pair and arbitrates the single memory

---
 rtl/mem_ctrl_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory access controller: FSM state and
// transfer-owner encodings, default widths, and timeout counter sizing.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 16;
  localparam int unsigned DATA_W_DEFAULT  = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_REQ  = 3'd2,
    ST_CAPT = 3'd3,
    ST_RESP = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Counter width able to hold the value 'limit' (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    if (limit < 2) return 1;
    return 32'($clog2(limit + 1));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is instruction fetch, bit 1 is load/store;
// on a tie the side that did not win last time is granted.
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  owner_t rr_last_q;
  owner_t rr_last_d;

  always_comb begin
    gnt       = 2'b00;
    rr_last_d = rr_last_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_last_q == OWN_LS) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (advance && (gnt != 2'b00)) begin
      rr_last_d = gnt[1] ? OWN_LS : OWN_IF;
    end
  end

  // Starts as if load/store won last, so fetch takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= OWN_LS;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences fetch and load/store transfers through the shared MAR/MDR pair,
// arbitrating the single memory port and bounding wait states with a timeout.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic              ls_err,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mar_ld,
  output logic [ADDR_W-1:0] mar_d,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              mdr_ld,
  input  logic [DATA_W-1:0] mdr_q
);

  localparam int unsigned CNT_W  = cnt_width(TIMEOUT);
  localparam bit          TO_EN  = (TIMEOUT != 0);

  state_t            state_q,  state_d;
  owner_t            owner_q,  owner_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic              we_q,     we_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [1:0]        arb_req;
  logic [1:0]        arb_gnt;
  logic              arb_adv;

  // Requests are masked during reset so no grant can escape while rst_n is low.
  assign arb_req = {ls_req, if_req} & {2{rst_n}};
  assign arb_adv = (state_q == ST_IDLE);
  assign cnt_inc = cnt_q + CNT_W'(1);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (arb_adv),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    if_gnt    = 1'b0;
    if_done   = 1'b0;
    if_err    = 1'b0;
    if_rdata  = '0;
    ls_gnt    = 1'b0;
    ls_done   = 1'b0;
    ls_err    = 1'b0;
    ls_rdata  = '0;
    mar_ld    = 1'b0;
    mar_d     = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mdr_ld    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_gnt != 2'b00) begin
          if_gnt  = arb_gnt[0];
          ls_gnt  = arb_gnt[1];
          state_d = ST_ADDR;
          if (arb_gnt[1]) begin
            owner_d = OWN_LS;
            addr_d  = ls_addr;
            we_d    = ls_we;
            wdata_d = ls_wdata;
          end else begin
            owner_d = OWN_IF;
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      ST_ADDR: begin
        mar_ld  = 1'b1;
        mar_d   = addr_q;
        cnt_d   = '0;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_wdata = wdata_q;
        cnt_d     = cnt_inc;
        if (mem_ready) begin
          state_d = we_q ? ST_RESP : ST_CAPT;
        end else if (TO_EN && (cnt_inc == CNT_W'(TIMEOUT))) begin
          state_d = ST_ERR;
        end
      end
      ST_CAPT: begin
        mdr_ld  = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (owner_q == OWN_LS) begin
          ls_done  = 1'b1;
          ls_rdata = we_q ? '0 : mdr_q;
        end else begin
          if_done  = 1'b1;
          if_rdata = mdr_q;
        end
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (owner_q == OWN_LS) begin
          ls_done = 1'b1;
          ls_err  = 1'b1;
        end else begin
          if_done = 1'b1;
          if_err  = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: memory/MAR/MDR model, a completion
// scoreboard, and per-scenario timing checks.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_done, if_err;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req = 1'b0;
  logic              ls_we = 1'b0;
  logic [ADDR_W-1:0] ls_addr = '0;
  logic [DATA_W-1:0] ls_wdata = '0;
  logic              ls_gnt, ls_done, ls_err;
  logic [DATA_W-1:0] ls_rdata;
  logic              mar_ld;
  logic [ADDR_W-1:0] mar_d;
  logic              mem_en, mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mdr_ld;
  logic [DATA_W-1:0] mdr_q = '0;

  typedef struct {
    bit          is_ls;
    bit          err;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  int          wait_cfg    = 0;
  bit          hang        = 1'b0;
  bit          ready_pulse = 1'b0;
  int          en_cnt;
  logic [15:0] mar_m        = '0;
  logic [15:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_err(if_err), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_err(ls_err), .ls_rdata(ls_rdata),
    .mar_ld(mar_ld), .mar_d(mar_d), .mem_en(mem_en), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mdr_ld(mdr_ld), .mdr_q(mdr_q)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_fn(input logic [15:0] a);
    if (a == 16'h0040) return 16'hBEEF;
    return a ^ 16'hC3A5;
  endfunction

  // Memory answers after wait_cfg stalled REQ cycles unless hung.
  assign mem_ready = (mem_en && !hang && (en_cnt >= wait_cfg)) || ready_pulse;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_cnt <= 0;
    else if (mem_en && !mem_ready) en_cnt <= en_cnt + 1;
    else en_cnt <= 0;
  end

  always @(posedge clk) begin
    if (mar_ld) mar_m <= mar_d;
    if (mdr_ld) mdr_q <= rd_fn(mar_m);
    if (mem_en && mem_we && mem_ready) begin
      last_wr_addr <= mar_m;
      last_wr_data <= mem_wdata;
    end
  end

  task automatic monitor();
    exp_t        e;
    logic [15:0] gr;
    logic        ge;
    logic        nz;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && (if_done || ls_done)) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: if_done=%0b ls_done=%0b with empty scoreboard", if_done, ls_done);
        end else begin
          e  = sb.pop_front();
          gr = ls_done ? ls_rdata : if_rdata;
          ge = ls_done ? ls_err : if_err;
          nz = ls_done ? ((if_rdata != 0) || if_err) : ((ls_rdata != 0) || ls_err);
          if (({ls_done, if_done} !== (e.is_ls ? 2'b10 : 2'b01)) || (ge !== e.err) ||
              (gr !== e.rdata) || nz) begin
            miscompares++;
            $display("FAIL completion: got ls_done=%0b if_done=%0b err=%0b rdata=%h nonowner_nz=%0b, expected ls=%0b err=%0b rdata=%h",
                     ls_done, if_done, ge, gr, nz, e.is_ls, e.err, e.rdata);
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Issue one transfer from IDLE and record when each strobe first appears.
  task automatic run_one(input bit is_ls, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input int waits, input bit no_ready,
                         input bit pulse_early,
                         output int t_gnt, output int t_mar, output int t_mdr,
                         output int t_done, output int n_en, output int n_we,
                         output logic [15:0] mar_seen);
    t_gnt = -1; t_mar = -1; t_mdr = -1; t_done = -1; n_en = 0; n_we = 0; mar_seen = '0;
    wait_cfg = waits;
    hang     = no_ready;
    sb.push_back('{is_ls, no_ready, (we || no_ready) ? 16'h0000 : rd_fn(addr)});
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int c = 0; c < 40; c++) begin
      ready_pulse = pulse_early && (c < 2);
      #1;
      if ((is_ls ? ls_gnt : if_gnt) && (t_gnt < 0)) t_gnt = c;
      if (mar_ld && (t_mar < 0)) begin t_mar = c; mar_seen = mar_d; end
      if (mdr_ld && (t_mdr < 0)) t_mdr = c;
      if (mem_en) n_en++;
      if (mem_en && mem_we) n_we++;
      if (is_ls ? ls_done : if_done) begin
        t_done = c;
        if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    ready_pulse = 1'b0;
    if (t_done < 0) begin
      if_req = 1'b0; ls_req = 1'b0; hang = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b1; ls_req = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_strobes", int'({if_gnt, ls_gnt, if_done, ls_done, if_err, ls_err,
                               mar_ld, mem_en, mem_we, mdr_ld}), 0);
    chk("reset_buses", int'(mar_d | mem_wdata | if_rdata | ls_rdata), 0);
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_if_read();
    int tg, tm, td, tq, ne, nw;
    logic [15:0] ms;
    run_one(1'b0, 1'b0, 16'h0040, 16'h0, 0, 1'b0, 1'b0, tg, tm, tq, td, ne, nw, ms);
    chk("ifrd_gnt_cycle", tg, 0);
    chk("ifrd_marld_cycle", tm, 1);
    chk("ifrd_mar_d", int'(ms), 16'h0040);
    chk("ifrd_mdrld_cycle", tq, 3);
    chk("ifrd_done_cycle", td, 4);
    chk("ifrd_req_cycles", ne, 1);
  endtask

  task automatic test_ls_write();
    int tg, tm, td, tq, ne, nw;
    logic [15:0] ms;
    run_one(1'b1, 1'b1, 16'h00A0, 16'h1234, 3, 1'b0, 1'b0, tg, tm, tq, td, ne, nw, ms);
    chk("lswr_gnt_cycle", tg, 0);
    chk("lswr_we_cycles", nw, 4);
    chk("lswr_done_cycle", td, 6);
    chk("lswr_no_mdrld", tq, -1);
    chk("lswr_mem_addr", int'(last_wr_addr), 16'h00A0);
    chk("lswr_mem_data", int'(last_wr_data), 16'h1234);
  endtask

  task automatic test_timeout();
    int tg, tm, td, tq, ne, nw;
    logic [15:0] ms;
    run_one(1'b1, 1'b0, 16'h0123, 16'h0, 0, 1'b1, 1'b0, tg, tm, tq, td, ne, nw, ms);
    hang = 1'b0;
    chk("tmo_req_cycles", ne, int'(TIMEOUT));
    chk("tmo_done_cycle", td, int'(TIMEOUT) + 2);
    chk("tmo_no_mdrld", tq, -1);
  endtask

  task automatic test_ready_ignored();
    int tg, tm, td, tq, ne, nw;
    logic [15:0] ms;
    run_one(1'b0, 1'b0, 16'h0300, 16'h0, 2, 1'b0, 1'b1, tg, tm, tq, td, ne, nw, ms);
    chk("early_rdy_req_cycles", ne, 3);
    chk("early_rdy_done_cycle", td, 6);
  endtask

  task automatic test_back_to_back();
    int order[4];
    int tg[4];
    int n  = 0;
    int dn = 0;
    rst_n = 1'b0;
    wait_cfg = 0; hang = 1'b0;
    if_addr = 16'h0100; ls_addr = 16'h0200; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{(i % 2) == 1, 1'b0, rd_fn(((i % 2) == 1) ? 16'h0200 : 16'h0100)});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (if_gnt && (n < 4)) begin order[n] = 0; tg[n] = c; n++; end
      if (ls_gnt && (n < 4)) begin order[n] = 1; tg[n] = c; n++; end
      if (if_done || ls_done) begin
        dn++;
        if (dn == 4) begin
          if_req = 1'b0; ls_req = 1'b0;
          @(negedge clk);
          break;
        end
      end
      @(negedge clk);
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("b2b_grant_count", n, 4);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("b2b_owner_%0d", i), order[i], i % 2);
      chk($sformatf("b2b_gnt_cycle_%0d", i), tg[i], 5 * i);
    end
  endtask

  task automatic test_reset_mid();
    int tg, tm, td, tq, ne, nw;
    logic [15:0] ms;
    hang = 1'b1;
    sb.push_back('{1'b0, 1'b1, 16'h0000});
    if_req = 1'b1; if_addr = 16'h0044;
    repeat (3) @(negedge clk);
    #1;
    chk("rstmid_in_req", int'(mem_en), 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rstmid_strobes", int'({if_gnt, ls_gnt, if_done, ls_done, if_err, ls_err,
                                mar_ld, mem_en, mem_we, mdr_ld}), 0);
    chk("rstmid_buses", int'(mar_d | mem_wdata | if_rdata | ls_rdata), 0);
    if_req = 1'b0; hang = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_one(1'b0, 1'b0, 16'h0040, 16'h0, 0, 1'b0, 1'b0, tg, tm, tq, td, ne, nw, ms);
    chk("rstmid_after_gnt", tg, 0);
    chk("rstmid_after_done", td, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_if_read();
    test_ls_write();
    test_timeout();
    test_ready_ignored();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
